// File: rtl/key_debounce8_if.sv
// Key conditioner bus: raw active-low keys in, debounced levels, press pulses and
// the encoder enable out.
interface key_debounce8_if;
  logic [7:0] iKey;
  logic [7:0] oData;
  logic [7:0] oPress;
  logic       oEI;

  modport master (output iKey, input oData, input oPress, input oEI);
  modport slave  (input iKey, output oData, output oPress, output oEI);
endinterface

// File: rtl/key_debounce8.sv
// Eight-channel key synchroniser/debouncer feeding an 8-3 priority encoder, with
// press pulses and a post-reset blanking period on the active-low encoder enable.
module key_debounce8 #(
  parameter int unsigned CNT_MAX = 1000000
) (
  input  logic          iClk,
  input  logic          iRst,
  key_debounce8_if.slave bus
);

  localparam logic [19:0] CntLast = 20'(CNT_MAX - 1);

  logic [7:0]  sync1;
  logic [7:0]  sync2;
  logic [7:0]  db;
  logic [7:0]  dbNext;
  logic [7:0]  fallNext;
  logic [7:0]  pressReg;
  logic [19:0] cnt     [8];
  logic [19:0] cntNext [8];
  logic [19:0] blk;
  logic        blkHit;
  logic        blkHit2;
  logic        eiReg;

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= bus.iKey;
      sync2 <= sync1;
    end
  end

  // Per-channel stability counter: any sample matching the accepted level restarts it.
  always_comb begin
    dbNext   = db;
    fallNext = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cntNext[i] = cnt[i];
      if (sync2[i] == db[i]) begin
        cntNext[i] = 20'd0;
      end else if (cnt[i] == CntLast) begin
        dbNext[i]   = sync2[i];
        cntNext[i]  = 20'd0;
        fallNext[i] = db[i] & ~sync2[i];
      end else begin
        cntNext[i] = cnt[i] + 20'd1;
      end
    end
  end

  // Debounced levels, counters and the one-cycle press pulses.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      db       <= 8'hFF;
      pressReg <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= 20'd0;
      end
    end else begin
      db       <= dbNext;
      pressReg <= fallNext;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cntNext[i];
      end
    end
  end

  // Blanking: blkHit marks the CNT_MAXth clean edge; two more stages drop oEI at CNT_MAX+2.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      blk     <= 20'd0;
      blkHit  <= 1'b0;
      blkHit2 <= 1'b0;
      eiReg   <= 1'b1;
    end else begin
      if (!blkHit) begin
        blk <= blk + 20'd1;
      end else begin
        blk <= blk;
      end
      blkHit  <= blkHit | (blk == CntLast);
      blkHit2 <= blkHit;
      eiReg   <= ~blkHit2;
    end
  end

  assign bus.oData  = db;
  assign bus.oPress = pressReg;
  assign bus.oEI    = eiReg;

endmodule

// File: tb/tb_key_debounce8.sv
// Scoreboard bench for key_debounce8 (CNT_MAX = 4): stimulus queues expected output
// changes with their edge numbers, a monitor pops one per observed output change.
module tb_key_debounce8;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [7:0] press;
    logic       ei;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        monEn;
  logic [16:0] last;
  int          cyc;
  int          checks;
  int          errors;
  exp_t        expQ[$];

  key_debounce8_if bus ();

  key_debounce8 #(.CNT_MAX(4)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExp(input int c, input logic [7:0] d, input logic [7:0] p, input logic e);
    exp_t x;
    x.cyc = c; x.data = d; x.press = p; x.ei = e;
    expQ.push_back(x);
  endtask

  task automatic checkNow(input string name, input logic [7:0] d, input logic [7:0] p, input logic e);
    checks++;
    if (bus.oData !== d || bus.oPress !== p || bus.oEI !== e) begin
      errors++;
      $display("FAIL %s: got data=%h press=%h ei=%b, want data=%h press=%h ei=%b",
               name, bus.oData, bus.oPress, bus.oEI, d, p, e);
    end
  endtask

  // Monitor: every change on the outputs must match the next queued expectation.
  initial begin
    logic [16:0] cur;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (monEn) begin
        cur = {bus.oData, bus.oPress, bus.oEI};
        if (cur !== last) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected change at edge %0d: data=%h press=%h ei=%b",
                     cyc, bus.oData, bus.oPress, bus.oEI);
          end else begin
            e = expQ.pop_front();
            if (e.cyc != cyc || cur !== {e.data, e.press, e.ei}) begin
              errors++;
              $display("FAIL event: got edge %0d data=%h press=%h ei=%b, want edge %0d data=%h press=%h ei=%b",
                       cyc, bus.oData, bus.oPress, bus.oEI, e.cyc, e.data, e.press, e.ei);
            end
          end
          last = cur;
        end
      end
    end
  end

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    monEn    = 1'b0;
    last     = 17'd0;
    rst      = 1'b1;
    bus.iKey = 8'hFF;

    // Reset and blanking
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkNow("reset", 8'hFF, 8'h00, 1'b1);
    end
    rst = 1'b0;
    pushExp(cyc + 6, 8'hFF, 8'h00, 1'b0);
    last  = {8'hFF, 8'h00, 1'b1};
    monEn = 1'b1;
    tick(10);

    // Clean press and release of key 5
    bus.iKey = 8'hDF;
    pushExp(cyc + 6, 8'hDF, 8'h20, 1'b0);
    pushExp(cyc + 7, 8'hDF, 8'h00, 1'b0);
    tick(10);
    bus.iKey = 8'hFF;
    pushExp(cyc + 6, 8'hFF, 8'h00, 1'b0);
    tick(10);

    // Bounce on key 3: low 3, high 1, then low held
    n = cyc;
    bus.iKey = 8'hF7;
    tick(3);
    bus.iKey = 8'hFF;
    tick(1);
    bus.iKey = 8'hF7;
    pushExp(n + 10, 8'hF7, 8'h08, 1'b0);
    pushExp(n + 11, 8'hF7, 8'h00, 1'b0);
    tick(10);
    bus.iKey = 8'hFF;
    pushExp(cyc + 6, 8'hFF, 8'h00, 1'b0);
    tick(10);

    // Glitch on key 0: three low cycles must be rejected
    bus.iKey = 8'hFE;
    tick(3);
    bus.iKey = 8'hFF;
    tick(12);

    // Simultaneous keys 7 and 2
    bus.iKey = 8'h7B;
    pushExp(cyc + 6, 8'h7B, 8'h84, 1'b0);
    pushExp(cyc + 7, 8'h7B, 8'h00, 1'b0);
    tick(10);
    bus.iKey = 8'hFF;
    pushExp(cyc + 6, 8'hFF, 8'h00, 1'b0);
    tick(10);

    // Reset mid-count on key 4
    bus.iKey = 8'hEF;
    tick(3);
    rst = 1'b1;
    pushExp(cyc + 1, 8'hFF, 8'h00, 1'b1);
    tick(1);
    rst = 1'b0;
    pushExp(cyc + 6, 8'hEF, 8'h10, 1'b0);
    pushExp(cyc + 7, 8'hEF, 8'h00, 1'b0);
    tick(10);
    bus.iKey = 8'hFF;
    pushExp(cyc + 6, 8'hFF, 8'h00, 1'b0);
    tick(10);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d expected events never seen, want 0", expQ.size());
    end
    checkNow("final", 8'hFF, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
